// File: rtl/golden_nonce_collector_if.sv
// ============================================================================
// Module      : golden_nonce_collector_if
// Description : Bundle between the hashing cores / JTAG work core and the
//               golden-nonce collector.
//               master : drives new_work and the per-core nonce reports,
//                        observes the nonce stream and status counters.
//               slave  : the collector itself.
//   new_work          1            flush request, one-cycle pulse
//   core_nonce_valid  NUM_CORES    per-core raw nonce strobe
//   core_nonce        32*NUM_CORES raw nonces, core i at [32i+31:32i]
//   new_nonce         1            one-cycle output strobe
//   word              32           corrected nonce, valid with new_nonce
//   fifo_level        log2(D)+1    current FIFO occupancy
//   drop_count        8            saturating count of discarded nonces
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface golden_nonce_collector_if #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_LW = $clog2(FIFO_DEPTH) + 1;

    logic                    new_work;
    logic [NUM_CORES-1:0]    core_nonce_valid;
    logic [32*NUM_CORES-1:0] core_nonce;
    logic                    new_nonce;
    logic [31:0]             word;
    logic [c_LW-1:0]         fifo_level;
    logic [7:0]              drop_count;

    modport master (
        output new_work, core_nonce_valid, core_nonce,
        input  new_nonce, word, fifo_level, drop_count
    );

    modport slave (
        input  new_work, core_nonce_valid, core_nonce,
        output new_nonce, word, fifo_level, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/golden_nonce_collector.sv
// ============================================================================
// Module      : golden_nonce_collector
// Description : Collects golden-nonce reports from NUM_CORES hashing cores,
//               subtracts the pipeline advance NONCE_OFFSET, buffers them in a
//               shared FIFO and emits them as one rate-limited stream
//               (new_nonce pulse + word) towards the JTAG core. new_work
//               flushes everything that is buffered.
//   Pipeline : per-core pending register -> round-robin arbiter -> FIFO ->
//              gap-limited output register (3 cycles valid-to-pulse).
// Ports       :
//   clk      in   single clock shared with cores and JTAG core
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of golden_nonce_collector_if (see that file)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module golden_nonce_collector #(
    parameter int          NUM_CORES    = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] NONCE_OFFSET = 32'd134,
    parameter int          MIN_GAP      = 4
) (
    input  wire                     clk,
    input  wire                     reset_n,
    golden_nonce_collector_if.slave bus
);
    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam int              c_LW       = c_AW + 1;
    localparam int              c_PW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int              c_GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(MIN_GAP - 1);
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(FIFO_DEPTH);
    localparam logic [c_PW-1:0] c_LAST     = c_PW'(NUM_CORES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] r_pending;
    logic [31:0]          r_pend_val [NUM_CORES];
    logic [c_PW-1:0]      r_ptr;
    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_LW-1:0]      r_level;
    logic [c_GW-1:0]      r_gap;
    logic                 r_new_nonce;
    logic [31:0]          r_word;
    logic [7:0]           r_drop;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [31:0]          w_corr [NUM_CORES];
    logic [NUM_CORES-1:0] w_cap;
    logic [NUM_CORES-1:0] w_drop;
    logic [NUM_CORES-1:0] w_grant_vec;
    logic                 w_grant;
    logic [c_PW-1:0]      w_grant_idx;
    logic [31:0]          w_grant_data;
    logic                 w_pop;
    logic                 w_can_push;
    logic [8:0]           w_drop_sum;

    // Output stage: pop whenever something is buffered and the gap timer has
    // expired. A flush edge suppresses the pop so nothing flushed escapes.
    assign w_pop = (r_level != '0) && (r_gap == '0) && !bus.new_work;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_can_push = (r_level != c_FULL) || w_pop;

    // Round-robin arbiter: first pending core at or after r_ptr, cyclically.
    // No grant on a flush edge so the pointer stays where it was.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        if (w_can_push && !bus.new_work) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                v_idx = int'(r_ptr) + k;
                if (v_idx >= NUM_CORES) begin
                    v_idx = v_idx - NUM_CORES;
                end
                if (!w_grant && r_pending[v_idx]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = c_PW'(v_idx);
                end
            end
            if (w_grant) begin
                w_grant_vec[w_grant_idx] = 1'b1;
            end
        end
    end

    assign w_grant_data = r_pend_val[w_grant_idx];

    // Capture decision per core. All-ones is the "no nonce" marker on the
    // downstream side, so a correction landing there cannot be forwarded.
    // An occupied slot accepts a new value only if it is drained this cycle.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_corr[i] = bus.core_nonce[32*i +: 32] - NONCE_OFFSET;
            w_cap[i]  = 1'b0;
            w_drop[i] = 1'b0;
            if (bus.core_nonce_valid[i] && !bus.new_work) begin
                if ((w_corr[i] == 32'hFFFF_FFFF) || (r_pending[i] && !w_grant_vec[i])) begin
                    w_drop[i] = 1'b1;
                end else begin
                    w_cap[i]  = 1'b1;
                end
            end
        end
    end

    // Several cores can drop in the same cycle; sum then saturate.
    always_comb begin
        w_drop_sum = {1'b0, r_drop};
        for (int i = 0; i < NUM_CORES; i++) begin
            w_drop_sum = w_drop_sum + {8'd0, w_drop[i]};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-core pending registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_pend_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.new_work) begin
                    r_pending[i] <= 1'b0;
                end else if (w_cap[i]) begin
                    r_pending[i]  <= 1'b1;
                    r_pend_val[i] <= w_corr[i];
                end else if (w_grant_vec[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: arbiter pointer and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= '0;
            r_drop <= '0;
        end else begin
            if (w_grant) begin
                r_ptr <= (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;
            end
            r_drop <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Shared FIFO. Storage needs no reset: occupancy is tracked by r_level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_mem[r_wr_ptr] <= w_grant_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.new_work) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: rate-limited output. The gap timer keeps counting through a
    // flush; word holds its last value between pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_new_nonce <= 1'b0;
            r_word      <= '0;
            r_gap       <= '0;
        end else begin
            r_new_nonce <= w_pop;
            if (w_pop) begin
                r_word <= r_mem[r_rd_ptr];
                r_gap  <= c_GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign bus.new_nonce  = r_new_nonce;
    assign bus.word       = r_word;
    assign bus.fifo_level = r_level;
    assign bus.drop_count = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_golden_nonce_collector.sv
// ============================================================================
// Module      : tb_golden_nonce_collector
// Description : Self-checking bench for golden_nonce_collector. A per-cycle
//               vector table covers single reports, wrap and the all-ones
//               filter; hand-written sequences cover arbitration order,
//               backpressure/saturation, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_golden_nonce_collector;
    localparam int NC = 4;
    localparam int FD = 8;
    localparam int MG = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    golden_nonce_collector_if #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) bus ();

    golden_nonce_collector #(
        .NUM_CORES   (NC),
        .FIFO_DEPTH  (FD),
        .NONCE_OFFSET(32'd134),
        .MIN_GAP     (MG)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder; also enforces the minimum pulse spacing.
    typedef struct {
        int          c;
        logic [31:0] w;
    } pulse_t;
    pulse_t pq[$];
    int     last_pulse = -1000;

    always @(negedge clk) begin
        if (bus.new_nonce === 1'b1) begin
            pq.push_back('{cyc, bus.word});
            n_checks++;
            if (cyc - last_pulse < MG) begin
                n_errors++;
                $display("FAIL pulse_gap: got %0d cycles, required >= %0d", cyc - last_pulse, MG);
            end
            last_pulse = cyc;
        end
    end

    typedef struct {
        logic [NC-1:0] vld;
        logic [127:0]  raw;
        logic          nw;
        logic          e_nn;
        logic [31:0]   e_word;
        logic [3:0]    e_lvl;
        logic [7:0]    e_drop;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [NC-1:0] v, input logic [127:0] r, input logic nw);
        bus.core_nonce_valid = v;
        bus.core_nonce       = r;
        bus.new_work         = nw;
    endtask

    // Advance n clock edges and settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0);
        #2 reset_n = 1'b0;
        tick(2);
        #2 reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int           c0;
        int           maxlvl;
        logic [127:0] raw_v;
        int           last_seq[NC];
        logic         ok;

        // Table: vector k is applied for one cycle, outputs checked after its edge.
        vt[0] = '{4'b0010, {32'h0, 32'h0, 32'h1000, 32'h0}, 1'b0, 1'b0, 32'h0,         4'd0, 8'd0};
        vt[1] = '{4'b0000, 128'h0,                            1'b0, 1'b0, 32'h0,         4'd1, 8'd0};
        vt[2] = '{4'b0000, 128'h0,                            1'b0, 1'b1, 32'h0000_0F7A, 4'd0, 8'd0};
        vt[3] = '{4'b0000, 128'h0,                            1'b0, 1'b0, 32'h0000_0F7A, 4'd0, 8'd0};
        vt[4] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h10},     1'b0, 1'b0, 32'h0000_0F7A, 4'd0, 8'd0};
        vt[5] = '{4'b0000, 128'h0,                            1'b0, 1'b0, 32'h0000_0F7A, 4'd1, 8'd0};
        vt[6] = '{4'b0000, 128'h0,                            1'b0, 1'b1, 32'hFFFF_FF8A, 4'd0, 8'd0};
        vt[7] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h85},     1'b0, 1'b0, 32'hFFFF_FF8A, 4'd0, 8'd1};
        vt[8] = '{4'b0000, 128'h0,                            1'b0, 1'b0, 32'hFFFF_FF8A, 4'd0, 8'd1};
        vt[9] = '{4'b0000, 128'h0,                            1'b0, 1'b0, 32'hFFFF_FF8A, 4'd0, 8'd1};

        reset_n = 1'b0;
        drive('0, '0, 1'b0);
        tick(2);
        #2 reset_n = 1'b1;
        tick(1);

        chk("reset_new_nonce", {31'd0, bus.new_nonce}, 32'd0);
        chk("reset_word",      bus.word, 32'd0);
        chk("reset_level",     {28'd0, bus.fifo_level}, 32'd0);
        chk("reset_drop",      {24'd0, bus.drop_count}, 32'd0);

        for (int k = 0; k < 10; k++) begin
            drive(vt[k].vld, vt[k].raw, vt[k].nw);
            tick(1);
            chk($sformatf("vec%0d_new_nonce", k), {31'd0, bus.new_nonce}, {31'd0, vt[k].e_nn});
            chk($sformatf("vec%0d_word", k), bus.word, vt[k].e_word);
            chk($sformatf("vec%0d_level", k), {28'd0, bus.fifo_level}, {28'd0, vt[k].e_lvl});
            chk($sformatf("vec%0d_drop", k), {24'd0, bus.drop_count}, {24'd0, vt[k].e_drop});
        end
        drive('0, '0, 1'b0);

        // ---- Arbitration: all four cores at once, then cores 3 and 0 ----
        do_reset();
        pq.delete();
        drive(4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        c0 = cyc;
        tick(1);
        drive('0, '0, 1'b0);
        tick(20);
        chk("arb_count", pq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (pq.size() > k) begin
                chk($sformatf("arb_word%0d", k), pq[k].w, 32'h1A + k);
                chk($sformatf("arb_cycle%0d", k), pq[k].c, c0 + 3 + 4 * k);
            end
        end

        pq.delete();
        drive(4'b1001, {32'h300, 32'h0, 32'h0, 32'h200}, 1'b0);
        c0 = cyc;
        tick(1);
        drive('0, '0, 1'b0);
        tick(12);
        chk("arb_wrap_count", pq.size(), 2);
        if (pq.size() == 2) begin
            chk("arb_wrap_first",  pq[0].w, 32'h17A);
            chk("arb_wrap_second", pq[1].w, 32'h27A);
            chk("arb_wrap_cycle",  pq[0].c, c0 + 3);
        end

        // ---- Backpressure: every core valid every cycle ----
        do_reset();
        pq.delete();
        maxlvl = 0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < NC; i++) begin
                raw_v[32*i +: 32] = (32'(i) << 24) | ((32'(k) << 4) + 32'h100);
            end
            drive(4'hF, raw_v, 1'b0);
            tick(1);
            if (int'(bus.fifo_level) > maxlvl) maxlvl = int'(bus.fifo_level);
        end
        drive('0, '0, 1'b0);
        tick(80);
        chk("bp_max_level",   maxlvl, FD);
        chk("bp_drop_sat",    {24'd0, bus.drop_count}, 32'hFF);
        chk("bp_final_level", {28'd0, bus.fifo_level}, 32'd0);
        chk("bp_emitted_min", {31'd0, pq.size() >= 30}, 32'd1);
        for (int i = 0; i < NC; i++) last_seq[i] = -1;
        ok = 1'b1;
        foreach (pq[j]) begin
            if (pq[j].w[31:24] >= NC) begin
                ok = 1'b0;
            end else if (int'(pq[j].w[23:0]) <= last_seq[pq[j].w[25:24]]) begin
                ok = 1'b0;
            end else begin
                last_seq[pq[j].w[25:24]] = int'(pq[j].w[23:0]);
            end
        end
        chk("bp_order_unique", {31'd0, ok}, 32'd1);

        // ---- Flush with five nonces queued ----
        do_reset();
        pq.delete();
        drive(4'hF, {32'h1003, 32'h1002, 32'h1001, 32'h1000}, 1'b0);
        c0 = cyc;
        tick(1);
        drive(4'b0001, {96'h0, 32'h2000}, 1'b0);
        tick(1);
        drive('0, '0, 1'b0);
        tick(4);
        chk("flush_pre_level", {28'd0, bus.fifo_level}, 32'd4);
        drive(4'b0100, {32'h0, 32'h5000, 64'h0}, 1'b1);
        tick(1);
        drive('0, '0, 1'b0);
        chk("flush_level",     {28'd0, bus.fifo_level}, 32'd0);
        chk("flush_suppress",  {31'd0, bus.new_nonce}, 32'd0);
        tick(20);
        chk("flush_pulses",    pq.size(), 1);
        chk("flush_drop",      {24'd0, bus.drop_count}, 32'd0);
        chk("flush_level_end", {28'd0, bus.fifo_level}, 32'd0);
        pq.delete();
        drive(4'b0010, {64'h0, 32'h3000, 32'h0}, 1'b0);
        c0 = cyc;
        tick(1);
        drive('0, '0, 1'b0);
        tick(6);
        chk("flush_fresh_count", pq.size(), 1);
        if (pq.size() == 1) begin
            chk("flush_fresh_word",  pq[0].w, 32'h2F7A);
            chk("flush_fresh_cycle", pq[0].c, c0 + 3);
        end

        // ---- Asynchronous reset mid-operation ----
        do_reset();
        pq.delete();
        drive(4'hF, {32'h4003, 32'h4002, 32'h4001, 32'h4000}, 1'b0);
        tick(1);
        drive('0, '0, 1'b0);
        tick(4);
        chk("rst_pre_level", {28'd0, bus.fifo_level}, 32'd3);
        chk("rst_pre_word",  bus.word, 32'h3F7A);
        pq.delete();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_new_nonce", {31'd0, bus.new_nonce}, 32'd0);
        chk("rst_async_word",      bus.word, 32'd0);
        chk("rst_async_level",     {28'd0, bus.fifo_level}, 32'd0);
        chk("rst_async_drop",      {24'd0, bus.drop_count}, 32'd0);
        tick(3);
        #2 reset_n = 1'b1;
        tick(10);
        chk("rst_no_stale", pq.size(), 0);
        drive(4'b0100, {32'h0, 32'h6000, 64'h0}, 1'b0);
        c0 = cyc;
        tick(1);
        drive('0, '0, 1'b0);
        tick(6);
        chk("rst_fresh_count", pq.size(), 1);
        if (pq.size() == 1) begin
            chk("rst_fresh_word",  pq[0].w, 32'h5F7A);
            chk("rst_fresh_cycle", pq[0].c, c0 + 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/golden_nonce_collector.md
Name: golden_nonce_collector

Overview:
- Upstream neighbour of the JTAG work/nonce core.
- Gathers golden-nonce reports from NUM_CORES hashing cores and corrects each nonce for hash-pipeline latency.
- Buffers the corrected nonces and emits them as a rate-limited single stream: a new_nonce pulse plus word, sampled by the JTAG core on clk.
- Flushes all buffered nonces when new work is latched.

Parameters:
- NUM_CORES, 4: number of hashing cores reporting nonces (1..8).
- FIFO_DEPTH, 8: shared nonce FIFO entries; power of two, at least 2.
- NONCE_OFFSET, 32'd134: value subtracted from each raw nonce to undo pipeline advance.
- MIN_GAP, 4: minimum number of cycles between new_nonce rising edges (at least 1).

Ports:
- clk  input  1  single clock shared with hashing cores and the JTAG core's clk domain.
- reset_n  input  1  asynchronous, active-low reset.
- new_work  input  1  one-cycle pulse from the JTAG core when a new job is latched; triggers a flush.
- core_nonce_valid  input  NUM_CORES  per-core one-cycle pulse; raw nonce valid.
- core_nonce  input  32*NUM_CORES  raw nonces; core i occupies bits [32i+31:32i].
- new_nonce  output  1  one-cycle pulse; word is valid in the same cycle.
- word  output  32  corrected golden nonce.
- fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  8  saturating count of discarded nonces.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All state clears; no nonce pulse may appear while reset is low.
  - new_nonce=0, word=0, fifo_level=0, drop_count=0.
  - All pending flags clear, round-robin pointer=0, gap counter=0 (ready).
- Stage 1, per-core capture:
  - Each core has a one-deep pending register.
  - At the edge where core_nonce_valid[i]=1, it stores core_nonce[i] minus NONCE_OFFSET, modulo 2^32 (wraps; no saturation), and sets pending[i].
  - If the corrected value is 32'hFFFFFFFF, it is not stored and drop_count increments. The downstream core treats all-ones as "no nonce".
  - If pending[i] is already set and not granted this cycle, the new nonce is discarded, drop_count increments, and the old value is kept.
  - If pending[i] is granted in the same cycle a new valid arrives, the new value is captured.
- Stage 2, round-robin arbiter:
  - Each cycle, if FIFO is not full and any pending bit is set: grant the lowest index at or above the pointer, searching cyclically.
  - The granted value is written to the FIFO, pending[grant] is cleared, and the pointer becomes (grant+1) mod NUM_CORES.
  - When the FIFO is full, no grant is made; pending values are held, not dropped.
- Stage 3, output:
  - When the FIFO is non-empty and the gap counter reads ready, pop the head into word and pulse new_nonce for exactly one cycle.
  - The gap counter then loads MIN_GAP-1 and counts down to ready, so pulses are at least MIN_GAP cycles apart.
  - word holds its last value between pulses.
- Latency: a valid pulse in cycle c with an empty pipeline and gap ready gives new_nonce high in cycle c+3.
- Same-cycle FIFO push and pop:
  - Both occur and level is unchanged.
  - This is allowed when full: the pop frees the slot, and the arbiter may grant in that cycle.
- Flush on new_work=1 (at that edge):
  - Clear all pending flags and empty the FIFO.
  - A core valid in the same cycle is discarded and not counted in drop_count.
  - Any output pulse scheduled for that edge is suppressed.
  - Round-robin pointer, gap counter, word and drop_count are unaffected.
- drop_count saturates at 8'hFF.
- Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.

Test Plan:
- Single report: core 1 valid with 32'h0000_1000, offset 134 → exactly one new_nonce pulse 3 cycles later, word=32'h0000_0F7A; fifo_level returns to 0.
- Wrap/filter: core 0 raw 32'h0000_0010 → word=32'hFFFF_FF8A. Raw 32'h0000_0085 (corrects to all-ones) → no pulse, drop_count=1.
- Arbitration: all 4 cores valid in the same cycle, nonces 32'hA0..A3 raw → words in core order 0,1,2,3, pulses exactly MIN_GAP=4 cycles apart. Then cores 3 and 0 together → core 0 first (pointer wrapped to 0).
- Backpressure: 4 cores valid every cycle with FIFO_DEPTH=8 → FIFO reaches 8 and arbiter stalls. Pending overwrites count in drop_count, saturating at 255. No nonce is emitted twice, and each stored nonce is emitted in FIFO order.
- Flush: 5 nonces queued, pulse new_work in the same cycle as a core 2 valid → fifo_level=0 next cycle, no further pulses, drop_count unchanged. A fresh valid afterwards is emitted with normal latency.
- Reset mid-operation: assert reset_n=0 asynchronously with FIFO at 3 and gap counting → outputs 0 immediately. After release, no stale pulses; the first new report is emitted at c+3.
